// File: rtl/boxhead_pkg.sv
// rtl/boxhead_pkg.sv - shared frame-buffer constants and write-entry types
package boxhead_pkg;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FB_ADDR_W = 20;
    localparam int PIX_IDX_W = 19;

    typedef logic [15:0] pixel_t;

    typedef struct packed {
        logic                 bank;
        logic [PIX_IDX_W-1:0] idx;
        pixel_t               data;
    } fb_write_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO of frame-buffer write entries
module sync_fifo
    import boxhead_pkg::*;
#(
    parameter int WIDTH = $bits(fb_write_t),
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/fb_write_port.sv
// rtl/fb_write_port.sv - clipped, buffered pixel writes into the back frame buffer
module fb_write_port #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = boxhead_pkg::SCREEN_W,
    parameter int SCREEN_H = boxhead_pkg::SCREEN_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  program_x,
    input  logic [9:0]  program_y,
    input  logic [15:0] program_data,
    input  logic        program_write,
    output logic        program_ready,
    input  logic        current_frame,
    input  logic        write_slot,
    output logic        sram_write_en,
    output logic [19:0] sram_write_addr,
    output logic [15:0] sram_write_data,
    output logic        idle,
    output logic        overflow,
    input  logic        overflow_clear,
    output logic [15:0] clip_count
);
    import boxhead_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [9:0]  W_LIM   = 10'(SCREEN_W);
    localparam logic [9:0]  H_LIM   = 10'(SCREEN_H);
    localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH - 2);

    fb_write_t      s1_entry;
    fb_write_t      head;
    fb_write_t      last_head;
    fb_write_t      shown;
    logic           s1_valid;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    occupancy;
    logic           in_bounds;
    logic           accept;
    logic           drop_clip;
    logic           drop_full;
    logic [PIX_IDX_W-1:0] pix_idx;

    assign in_bounds = (program_x < W_LIM) && (program_y < H_LIM);
    // Row stride of 640 built from shifts: 512 + 128.
    assign pix_idx   = {program_y, 9'b0} + {2'b0, program_y, 7'b0} + {9'b0, program_x};

    // Reserve a slot for the entry that may still be sitting in stage 1.
    assign occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
    assign program_ready = (occupancy <= OCC_MAX);

    assign accept    = program_write & in_bounds & program_ready;
    assign drop_clip = program_write & ~in_bounds;
    assign drop_full = program_write & in_bounds & ~program_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_entry   <= '0;
            overflow   <= 1'b0;
            clip_count <= '0;
            last_head  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_entry <= '{bank: ~current_frame, idx: pix_idx, data: program_data};
            end
            if (drop_clip && clip_count != 16'hFFFF) clip_count <= clip_count + 1'b1;
            if (drop_full)           overflow <= 1'b1;
            else if (overflow_clear) overflow <= 1'b0;
            if (!fifo_empty) last_head <= head;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fb_write_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s1_valid),
        .push_data (s1_entry),
        .pop       (sram_write_en),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sram_write_en   = write_slot & ~fifo_empty;
    assign shown           = fifo_empty ? last_head : head;
    assign sram_write_addr = {shown.bank, shown.idx};
    assign sram_write_data = shown.data;
    assign idle            = ~s1_valid & fifo_empty;
endmodule

// File: tb/tb_fb_write_port.sv
// tb/tb_fb_write_port.sv - randomized bench with queue-based reference model for fb_write_port
module tb_fb_write_port;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  p_x, p_y;
    logic [15:0] p_data;
    logic        p_write, cur_frame, slot, ov_clr;
    logic        program_ready, sram_write_en, idle, overflow;
    logic [19:0] sram_write_addr;
    logic [15:0] sram_write_data, clip_count;

    fb_write_port #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .program_x       (p_x),
        .program_y       (p_y),
        .program_data    (p_data),
        .program_write   (p_write),
        .program_ready   (program_ready),
        .current_frame   (cur_frame),
        .write_slot      (slot),
        .sram_write_en   (sram_write_en),
        .sram_write_addr (sram_write_addr),
        .sram_write_data (sram_write_data),
        .idle            (idle),
        .overflow        (overflow),
        .overflow_clear  (ov_clr),
        .clip_count      (clip_count)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        bank;
        int          idx;
        logic [15:0] data;
        int          avail;
    } ent_t;

    ent_t        q[$];
    logic [19:0] iss[$];
    int          cyc = 0;
    int          m_clip = 0;
    bit          m_ov = 0;
    logic [19:0] m_last_addr = '0;
    logic [15:0] m_last_data = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        bit head_ok, exp_en, rdy;
        #1;
        head_ok = (q.size() > 0) && (q[0].avail <= cyc);
        if (head_ok) begin
            m_last_addr = {q[0].bank, 19'(q[0].idx)};
            m_last_data = q[0].data;
        end
        exp_en = slot && head_ok;
        rdy    = (q.size() <= DEPTH - 2);
        chk("write_en",   32'(sram_write_en),   32'(exp_en));
        chk("write_addr", 32'(sram_write_addr), 32'(m_last_addr));
        chk("write_data", 32'(sram_write_data), 32'(m_last_data));
        chk("ready",      32'(program_ready),   32'(rdy));
        chk("idle",       32'(idle),            32'(q.size() == 0));
        chk("overflow",   32'(overflow),        32'(m_ov));
        chk("clip_count", 32'(clip_count),      32'(m_clip));
        if (sram_write_en) iss.push_back(sram_write_addr);
        if (exp_en) void'(q.pop_front());
        if (ov_clr) m_ov = 0;
        if (p_write) begin
            if (p_x >= 640 || p_y >= 480) begin
                if (m_clip < 65535) m_clip++;
            end else if (!rdy) begin
                m_ov = 1;
            end else begin
                q.push_back('{~cur_frame, int'(p_y) * 640 + int'(p_x), p_data, cyc + 2});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic strobe(int x, int y, logic [15:0] d);
        p_x = 10'(x); p_y = 10'(y); p_data = d; p_write = 1'b1;
        tick();
        p_write = 1'b0;
    endtask

    task automatic wait_cycles(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; p_x = '0; p_y = '0; p_data = '0; p_write = 1'b0;
        cur_frame = 1'b0; slot = 1'b0; ov_clr = 1'b0;
        #25;
        chk("rst_en",    32'(sram_write_en),   32'd0);
        chk("rst_addr",  32'(sram_write_addr), 32'd0);
        chk("rst_idle",  32'(idle),            32'd1);
        chk("rst_ready", 32'(program_ready),   32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Basic write
        slot = 1'b1; iss.delete();
        strobe(3, 2, 16'hF800);
        wait_cycles(3);
        chk("basic_count", 32'(iss.size()), 32'd1);
        if (iss.size() > 0) chk("basic_addr", 32'(iss[0]), 32'h80503);
        chk("basic_idle", 32'(idle), 32'd1);

        // Clipping and the far corner
        iss.delete();
        strobe(640, 0, 16'h1111);
        strobe(0, 480, 16'h2222);
        wait_cycles(3);
        chk("clip_none_issued", 32'(iss.size()), 32'd0);
        chk("clip_count_lit", 32'(clip_count), 32'd2);
        chk("clip_no_ovf", 32'(overflow), 32'd0);
        strobe(639, 479, 16'h07E0);
        wait_cycles(3);
        chk("corner_count", 32'(iss.size()), 32'd1);
        if (iss.size() > 0) chk("corner_addr", 32'(iss[0]), 32'hCAFFF);

        // Backpressure
        slot = 1'b0; iss.delete();
        for (int i = 0; i < 20; i++) strobe(i, 1, 16'(i));
        wait_cycles(1);
        chk("bp_ready_low", 32'(program_ready), 32'd0);
        chk("bp_overflow",  32'(overflow),      32'd1);
        slot = 1'b1;
        wait_cycles(20);
        chk("bp_drained", 32'(iss.size()), 32'd15);
        for (int i = 0; i < iss.size() && i < 15; i++)
            chk("bp_order", 32'(iss[i]), 32'h80000 + 32'(640 + i));
        ov_clr = 1'b1; tick(); ov_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Concurrent push/pop, back-to-back
        iss.delete();
        for (int i = 0; i < 100; i++)
            strobe($urandom_range(639), $urandom_range(479), 16'($urandom));
        wait_cycles(4);
        chk("b2b_count", 32'(iss.size()), 32'd100);
        chk("b2b_ovf", 32'(overflow), 32'd0);

        // Bank latch across a frame toggle
        slot = 1'b0; cur_frame = 1'b1; iss.delete();
        for (int i = 0; i < 4; i++) strobe(10 + i, 20, 16'hABC0 + 16'(i));
        cur_frame = 1'b0;
        tick();
        slot = 1'b1;
        wait_cycles(6);
        chk("latch_count", 32'(iss.size()), 32'd4);
        for (int i = 0; i < iss.size(); i++) chk("latch_bank", 32'(iss[i][19]), 32'd0);
        iss.delete();
        strobe(5, 5, 16'h0001);
        wait_cycles(3);
        chk("new_bank_count", 32'(iss.size()), 32'd1);
        if (iss.size() > 0) chk("new_bank", 32'(iss[0][19]), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            p_x = 10'($urandom_range(700)); p_y = 10'($urandom_range(520));
            p_data = 16'($urandom); p_write = ($urandom_range(3) != 0);
            slot = ($urandom_range(2) == 0); cur_frame = ($urandom_range(7) == 0) ? ~cur_frame : cur_frame;
            ov_clr = ($urandom_range(15) == 0);
            tick();
        end
        p_write = 1'b0; ov_clr = 1'b0; slot = 1'b1;
        wait_cycles(20);

        // Asynchronous reset with entries queued
        slot = 1'b0;
        for (int i = 0; i < 5; i++) strobe(100 + i, 7, 16'h5555);
        wait_cycles(2);
        slot = 1'b1;
        #5 reset = 1'b1;
        #1;
        chk("arst_en",   32'(sram_write_en), 32'd0);
        chk("arst_idle", 32'(idle),          32'd1);
        q.delete(); m_clip = 0; m_ov = 0; m_last_addr = '0; m_last_data = '0;
        @(negedge clk);
        reset = 1'b0;
        iss.delete();
        wait_cycles(10);
        chk("arst_no_stale", 32'(iss.size()), 32'd0);
        chk("arst_clip",     32'(clip_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_write_port.md
Name: fb_write_port

Overview:
- Responder end of the pixel "program" interface driven by the copy engine and other frame-buffer writers.
- Accepts (x, y, data) pixel-write strobes and clips them to the visible screen.
- Computes the SRAM word address in the back buffer, i.e. the buffer not currently displayed.
- Buffers writes in a FIFO and drains them only in SRAM write slots granted by the SRAM controller, so rendering never stalls VGA readout.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- program_x  in  10  pixel column.
- program_y  in  10  pixel row.
- program_data  in  16  RGB565 pixel.
- program_write  in  1  one-cycle write strobe; one pixel per high cycle.
- program_ready  out  1  a write presented this cycle will be accepted.
- current_frame  in  1  buffer currently displayed; writes target ~current_frame.
- write_slot  in  1  SRAM controller grants a write this cycle.
- sram_write_en  out  1  write issued this cycle.
- sram_write_addr  out  20  {bank, 19-bit linear pixel index}.
- sram_write_data  out  16  pixel data.
- idle  out  1  pipeline stage and FIFO are both empty.
- overflow  out  1  sticky: a write was dropped for lack of space.
- overflow_clear  in  1  synchronous clear of overflow.
- clip_count  out  16  saturating count of writes dropped by clipping.

Behaviour:
- Reset (asynchronous) values:
  - FIFO empty, stage-1 valid = 0, count = 0.
  - sram_write_en = 0, sram_write_addr = 0, sram_write_data = 0.
  - idle = 1, overflow = 0, clip_count = 0, program_ready = 1.
- Stage 1 (registered), on a cycle where program_write = 1:
  - If x >= SCREEN_W or y >= SCREEN_H: drop the write, clip_count += 1 (saturate at 0xFFFF), stage-1 valid = 0.
  - Else if program_ready = 0: drop the write, overflow <= 1.
  - Else: stage-1 <= {~current_frame, y*640 + x, data}, valid = 1.
  - y*640 is computed as (y<<9) + (y<<7) into 19 bits. Maximum index 307199 < 2^19, so there is no overflow.
  - Bank is sampled from current_frame in the same cycle as the strobe.
- Stage 2: when stage-1 valid = 1, the entry is pushed into the FIFO on the following clock edge.
- program_ready = (fifo_count + stage1_valid) <= DEPTH-2. This guarantees room for the in-flight stage-1 entry.
- Drain (combinational outputs from FIFO head):
  - sram_write_en = write_slot & ~fifo_empty.
  - sram_write_addr and sram_write_data show the FIFO head whenever the FIFO is non-empty; they hold the last value otherwise.
  - The head is popped on any edge where sram_write_en = 1.
- Latency: strobe at edge N -> in FIFO after edge N+2 -> earliest sram_write_en during cycle N+2 with write_slot = 1. The FIFO-to-output path is zero-latency when write_slot is high.
- Simultaneous push and pop: count is unchanged and both complete. A push into an empty FIFO is visible at the head the next cycle, not the same cycle.
- Order: pixel writes are issued to SRAM in strobe order, with no merging or reordering.
- overflow: set on a drop; cleared only by overflow_clear or reset. If overflow_clear and a drop occur in the same cycle, set wins.
- idle = ~stage1_valid & fifo_empty. Frame-swap logic waits for idle before toggling current_frame.
- current_frame change with entries pending: pending entries keep the bank latched at strobe time.
- Reset mid-operation: all pending writes are discarded and no partial SRAM write is issued after reset asserts.

Decomposition:
- Package boxhead_pkg:
  - SCREEN_W, SCREEN_H, FB_ADDR_W = 20, PIX_IDX_W = 19.
  - typedef pixel_t (16-bit RGB565).
  - typedef fb_write_t struct {bank, idx, data} (36 bits).
- Sub-module sync_fifo:
  - Parameterised by width and DEPTH; stores fb_write_t.
  - Outputs: head, empty, count.
  - No full output; full is derived from count.
- fb_write_port holds stage 1, clipping, counters and the ready/overflow logic.

Test Plan:
- Basic write: x=3, y=2, data=0xF800, current_frame=0, write_slot held 1 -> one sram_write_en pulse, addr = 0x80503 (bank 1, idx 1283), data 0xF800, two cycles after the strobe; idle returns to 1.
- Clipping: x=640, y=0 and x=0, y=480 strobes -> no sram_write_en, clip_count = 2, overflow stays 0; x=639, y=479 -> idx 307199 issued.
- Backpressure: write_slot = 0, strobe every cycle for 20 cycles with DEPTH=16 -> exactly 15 accepted; program_ready falls; overflow = 1. Then write_slot = 1 -> 15 writes drain in order, idx matching the first 15 strobes.
- Concurrent push/pop: write_slot = 1 constantly, 100 back-to-back strobes -> 100 writes in order, program_ready never low, overflow 0.
- Bank latch: queue 4 writes with current_frame=1 and write_slot=0, toggle current_frame to 0, then drain -> all 4 addresses have bit 19 = 0; a new strobe afterward gives bit 19 = 1.
- Async reset with 5 entries queued: assert reset between edges -> sram_write_en = 0 and idle = 1 immediately; after release no stale writes appear and clip_count = 0.
